// File: rtl/cap_decoder_win_if.sv
// Camera-side and FIFO-side signal bundle for cap_decoder_win.
// The master modport drives camera pins, configuration and FIFOFULL; the slave (decoder) drives the FIFO write side.
interface cap_decoder_win_if #(
  parameter int CNT_W  = 12,
  parameter int FCNT_W = 8
);
  logic [7:0]        CAMDATA;
  logic              HREF;
  logic              VSYNC;
  logic              CAPON;
  logic              ORDER;
  logic [CNT_W-1:0]  HSTART;
  logic [CNT_W-1:0]  HSIZE;
  logic [CNT_W-1:0]  VSTART;
  logic [CNT_W-1:0]  VSIZE;
  logic              FIFOFULL;
  logic [47:0]       FIFOIN;
  logic              FIFOWR;
  logic              FIFORST;
  logic              CAPACT;
  logic              OVF;
  logic [FCNT_W-1:0] FRMCNT;

  modport master (
    output CAMDATA, HREF, VSYNC, CAPON, ORDER, HSTART, HSIZE, VSTART, VSIZE, FIFOFULL,
    input  FIFOIN, FIFOWR, FIFORST, CAPACT, OVF, FRMCNT
  );

  modport slave (
    input  CAMDATA, HREF, VSYNC, CAPON, ORDER, HSTART, HSIZE, VSTART, VSIZE, FIFOFULL,
    output FIFOIN, FIFOWR, FIFORST, CAPACT, OVF, FRMCNT
  );
endinterface

// File: rtl/cap_decoder_win.sv
// YUV 4:2:2 camera byte stream to paired 24-bit RGB words, with crop window,
// selectable byte order, frame-aligned capture enable and FIFO overflow tracking.
module cap_decoder_win #(
  parameter int CNT_W  = 12,
  parameter int FCNT_W = 8
) (
  input  logic              PCLK,
  input  logic              PRST,
  cap_decoder_win_if.slave  bus
);
  localparam int ACC_W = 20;

  function automatic logic signed [ACC_W-1:0] sx(input logic [7:0] b,
                                                  input logic signed [ACC_W-1:0] off);
    return $signed({{(ACC_W-8){1'b0}}, b}) - off;
  endfunction

  function automatic logic [7:0] rnd_sat(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] t;
    t = (s + ACC_W'(128)) >>> 8;
    if (t < 0)                 return 8'd0;
    else if (t > ACC_W'(255))  return 8'hFF;
    else                       return t[7:0];
  endfunction

  logic [7:0]              r_cam_ff;
  logic                    r_href_ff, r_href_d, r_vsync_ff, r_vsync_d;
  logic [CNT_W:0]          r_bcnt;
  logic [CNT_W-1:0]        r_lcnt;
  logic [7:0]              r_b0, r_b1, r_b2;
  logic                    r_capact, r_ovf;
  logic [FCNT_W-1:0]       r_frmcnt;
  logic [7:0]              r_u_p0, r_y0_p0, r_v_p0, r_y1_p0;
  logic                    r_vld_p0;
  logic signed [ACC_W-1:0] r_c0_p1, r_c1_p1, r_re_p1, r_gd_p1, r_ge_p1, r_bd_p1;
  logic                    r_vld_p1;
  logic [47:0]             r_rgb_p2;
  logic                    r_vld_p2;

  logic                    w_fstart, w_quad_done, w_in_win;
  logic [1:0]              w_phase;
  logic [CNT_W:0]          w_xpair, w_hend, w_vend;
  logic [7:0]              w_u, w_y0, w_v, w_y1;
  logic [23:0]             w_px0, w_px1;

  assign w_fstart    = r_vsync_d & ~r_vsync_ff;
  assign w_phase     = r_bcnt[1:0];
  assign w_quad_done = r_href_ff & ~r_vsync_ff & (w_phase == 2'd3);
  // Window test is done one bit wider so START+SIZE never wraps.
  assign w_xpair     = {1'b0, r_bcnt[CNT_W:2], 1'b0};
  assign w_hend      = {1'b0, bus.HSTART} + {1'b0, bus.HSIZE};
  assign w_vend      = {1'b0, bus.VSTART} + {1'b0, bus.VSIZE};
  assign w_in_win    = (w_xpair >= {1'b0, bus.HSTART}) && (w_xpair < w_hend) &&
                       (r_lcnt >= bus.VSTART) && ({1'b0, r_lcnt} < w_vend);

  always_comb begin
    w_u  = r_b0;
    w_y0 = r_b1;
    w_v  = r_b2;
    w_y1 = r_cam_ff;
    if (bus.ORDER) begin
      w_y0 = r_b0;
      w_u  = r_b1;
      w_y1 = r_b2;
      w_v  = r_cam_ff;
    end
  end

  always_ff @(posedge PCLK) begin
    r_cam_ff <= bus.CAMDATA;
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      r_href_ff  <= 1'b0;
      r_href_d   <= 1'b0;
      r_vsync_ff <= 1'b0;
      r_vsync_d  <= 1'b0;
    end else begin
      r_href_ff  <= bus.HREF;
      r_href_d   <= r_href_ff;
      r_vsync_ff <= bus.VSYNC;
      r_vsync_d  <= r_vsync_ff;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      r_bcnt <= '0;
      r_lcnt <= '0;
    end else begin
      if (r_vsync_ff || !r_href_ff) r_bcnt <= '0;
      else                          r_bcnt <= r_bcnt + 1'b1;
      if (r_vsync_ff || w_fstart)
        r_lcnt <= '0;
      else if (r_href_d && !r_href_ff && (r_lcnt != '1))
        r_lcnt <= r_lcnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      r_capact <= 1'b0;
      r_ovf    <= 1'b0;
      r_frmcnt <= '0;
    end else if (w_fstart) begin
      r_capact <= bus.CAPON;
      r_ovf    <= 1'b0;
      if (r_capact) r_frmcnt <= r_frmcnt + 1'b1;
    end else if (r_vld_p2 && bus.FIFOFULL && !r_vsync_ff) begin
      r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p0 <= w_quad_done & r_capact & w_in_win;
      r_vld_p1 <= r_vld_p0 & ~r_vsync_ff;
      r_vld_p2 <= r_vld_p1 & ~r_vsync_ff;
    end
  end

  // p0: byte demux, quad latched on the fourth byte
  always_ff @(posedge PCLK) begin
    if (r_href_ff) begin
      case (w_phase)
        2'd0:    r_b0 <= r_cam_ff;
        2'd1:    r_b1 <= r_cam_ff;
        2'd2:    r_b2 <= r_cam_ff;
        default: ;
      endcase
    end
    if (w_quad_done) begin
      r_u_p0  <= w_u;
      r_y0_p0 <= w_y0;
      r_v_p0  <= w_v;
      r_y1_p0 <= w_y1;
    end
  end

  // p1: colour-conversion products
  always_ff @(posedge PCLK) begin
    if (r_vld_p0) begin
      r_c0_p1 <= sx(r_y0_p0, ACC_W'(16))  * ACC_W'(298);
      r_c1_p1 <= sx(r_y1_p0, ACC_W'(16))  * ACC_W'(298);
      r_re_p1 <= sx(r_v_p0,  ACC_W'(128)) * ACC_W'(409);
      r_gd_p1 <= sx(r_u_p0,  ACC_W'(128)) * ACC_W'(100);
      r_ge_p1 <= sx(r_v_p0,  ACC_W'(128)) * ACC_W'(208);
      r_bd_p1 <= sx(r_u_p0,  ACC_W'(128)) * ACC_W'(516);
    end
  end

  assign w_px0 = {rnd_sat(r_c0_p1 + r_re_p1),
                  rnd_sat(r_c0_p1 - r_gd_p1 - r_ge_p1),
                  rnd_sat(r_c0_p1 + r_bd_p1)};
  assign w_px1 = {rnd_sat(r_c1_p1 + r_re_p1),
                  rnd_sat(r_c1_p1 - r_gd_p1 - r_ge_p1),
                  rnd_sat(r_c1_p1 + r_bd_p1)};

  // p2: summed, rounded and clamped output word
  always_ff @(posedge PCLK) begin
    if (PRST)          r_rgb_p2 <= '0;
    else if (r_vld_p1) r_rgb_p2 <= {w_px1, w_px0};
  end

  assign bus.FIFOIN  = r_rgb_p2;
  assign bus.FIFOWR  = r_vld_p2 & ~bus.FIFOFULL & ~r_vsync_ff;
  assign bus.FIFORST = PRST | r_vsync_ff;
  assign bus.CAPACT  = r_capact;
  assign bus.OVF     = r_ovf;
  assign bus.FRMCNT  = r_frmcnt;
endmodule

// File: tb/tb_cap_decoder_win.sv
// Randomized frame-level bench for cap_decoder_win with a queue scoreboard and
// a behavioural YUV->RGB / crop-window reference model.
module tb_cap_decoder_win;
  localparam int CNT_W  = 12;
  localparam int FCNT_W = 8;

  logic PCLK = 1'b0;
  logic PRST = 1'b1;

  cap_decoder_win_if #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) bus ();

  cap_decoder_win #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .PCLK (PCLK),
    .PRST (PRST),
    .bus  (bus)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct { int due; logic [47:0] word; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n_drop = 0;
  int drop_base = 0;
  bit mon_en = 1'b0;
  logic              m_capact = 1'b0;
  logic [FCNT_W-1:0] m_frmcnt = '0;
  logic [7:0]        pat[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [7:0] sat(input int x);
    if (x < 0)   return 8'd0;
    if (x > 255) return 8'd255;
    return x[7:0];
  endfunction

  function automatic logic [23:0] rgb(input int y, input int u, input int v);
    int c, d, e;
    c = 298 * (y - 16);
    d = u - 128;
    e = v - 128;
    return {sat((c + 409 * e + 128) >>> 8),
            sat((c - 100 * d - 208 * e + 128) >>> 8),
            sat((c + 516 * d + 128) >>> 8)};
  endfunction

  // Monitor: every cycle either the head word is due or no write may appear.
  always @(negedge PCLK) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL word_due: word due at cycle %0d not handled at cycle %0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        if (bus.FIFOFULL) begin
          chk("drop_no_write", {47'd0, bus.FIFOWR}, 48'd0);
          n_drop++;
        end else begin
          chk("fifowr", {47'd0, bus.FIFOWR}, 48'd1);
          chk("fifoin", bus.FIFOIN, sb[0].word);
        end
        void'(sb.pop_front());
      end else if (bus.FIFOWR !== 1'b0) begin
        chk("spurious_write", {47'd0, bus.FIFOWR}, 48'd0);
      end
    end
  end

  task automatic drop_inflight();
    while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
  endtask

  task automatic run_frame(input int wpx, input int nl, input int hs, input int hsz,
                           input int vs, input int vsz, input bit order, input bit capon,
                           input int full_pct, input int trunc, input bit mid_en,
                           input bit mid_val, input bit use_fixed, input logic [47:0] fixed_exp);
    logic [7:0] qb[4];
    logic [7:0] b, u, v, y0, y1;
    int nbytes, tpos, x;
    bit done;
    bus.HREF     = 1'b0;
    bus.VSYNC    = 1'b1;
    bus.FIFOFULL = 1'b0;
    bus.CAPON    = capon;
    bus.ORDER    = order;
    bus.HSTART   = CNT_W'(hs);
    bus.HSIZE    = CNT_W'(hsz);
    bus.VSTART   = CNT_W'(vs);
    bus.VSIZE    = CNT_W'(vsz);
    repeat (3) tick();
    bus.VSYNC = 1'b0;
    if (m_capact) m_frmcnt = m_frmcnt + 1'b1;
    m_capact  = capon;
    drop_base = n_drop;
    repeat (4) tick();
    done = 1'b0;
    for (int l = 0; l < nl && !done; l++) begin
      nbytes = 2 * wpx + (($urandom_range(3) == 0) ? $urandom_range(1, 3) : 0);
      tpos   = $urandom_range(1, nbytes - 1);
      for (int i = 0; i < nbytes && !done; i++) begin
        if (trunc != 0 && l == nl - 1 && i == tpos) begin
          drop_inflight();
          bus.HREF     = 1'b0;
          bus.FIFOFULL = 1'b0;
          if (trunc == 1) begin
            bus.VSYNC = 1'b1;
            tick();
            chk("vs_fiforst", {47'd0, bus.FIFORST}, 48'd1);
            chk("vs_fifowr", {47'd0, bus.FIFOWR}, 48'd0);
          end else begin
            PRST      = 1'b1;
            m_capact  = 1'b0;
            m_frmcnt  = '0;
            drop_base = n_drop;
            tick();
            chk("rst_fiforst", {47'd0, bus.FIFORST}, 48'd1);
            chk("rst_fifowr", {47'd0, bus.FIFOWR}, 48'd0);
            chk("rst_capact", {47'd0, bus.CAPACT}, 48'd0);
            tick();
            PRST = 1'b0;
          end
          done = 1'b1;
        end else begin
          b = (pat.size() == 4) ? pat[i % 4] : 8'($urandom_range(255));
          bus.CAMDATA  = b;
          bus.HREF     = 1'b1;
          bus.FIFOFULL = (full_pct > 0) && ($urandom_range(99) < full_pct);
          qb[i % 4]    = b;
          if (i % 4 == 3 && i < 2 * wpx) begin
            x = 2 * (i / 4);
            if (order == 1'b0) begin
              u = qb[0]; y0 = qb[1]; v = qb[2]; y1 = qb[3];
            end else begin
              y0 = qb[0]; u = qb[1]; y1 = qb[2]; v = qb[3];
            end
            if (m_capact && x >= hs && x < hs + hsz && l >= vs && l < vs + vsz)
              sb.push_back('{due: cyc + 4,
                             word: use_fixed ? fixed_exp : {rgb(y1, u, v), rgb(y0, u, v)}});
          end
          tick();
          if (mid_en && l == 0 && i == 0) bus.CAPON = mid_val;
        end
      end
      if (!done) begin
        bus.HREF = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          bus.FIFOFULL = (full_pct > 0) && ($urandom_range(99) < full_pct);
          tick();
        end
      end
    end
    bus.HREF = 1'b0;
    repeat (6) begin
      bus.FIFOFULL = (full_pct > 0) && ($urandom_range(99) < full_pct);
      tick();
    end
    bus.FIFOFULL = 1'b0;
    bus.VSYNC    = 1'b1;
    repeat (2) tick();
    chk("ovf", {47'd0, bus.OVF}, {47'd0, (n_drop != drop_base)});
    chk("capact", {47'd0, bus.CAPACT}, {47'd0, m_capact});
    chk("frmcnt", 48'(bus.FRMCNT), 48'(m_frmcnt));
    chk("sb_drained", 48'(sb.size()), 48'd0);
  endtask

  initial begin
    int wpx, nl, hs, hsz, vs, vsz, tr;
    bus.CAMDATA  = 8'd0;
    bus.HREF     = 1'b0;
    bus.VSYNC    = 1'b1;
    bus.CAPON    = 1'b0;
    bus.ORDER    = 1'b0;
    bus.HSTART   = '0;
    bus.HSIZE    = '0;
    bus.VSTART   = '0;
    bus.VSIZE    = '0;
    bus.FIFOFULL = 1'b0;
    PRST = 1'b1;
    repeat (3) tick();
    chk("reset_fifowr", {47'd0, bus.FIFOWR}, 48'd0);
    chk("reset_fiforst", {47'd0, bus.FIFORST}, 48'd1);
    chk("reset_capact", {47'd0, bus.CAPACT}, 48'd0);
    chk("reset_ovf", {47'd0, bus.OVF}, 48'd0);
    chk("reset_frmcnt", 48'(bus.FRMCNT), 48'd0);
    chk("reset_fifoin", bus.FIFOIN, 48'd0);
    PRST = 1'b0;
    tick();
    mon_en = 1'b1;

    // Directed colour words, full-frame window.
    pat = '{8'd128, 8'd235, 8'd128, 8'd16};
    run_frame(8, 2, 0, 8, 0, 2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 48'h000000_FFFFFF);
    pat = '{8'd235, 8'd128, 8'd16, 8'd128};
    run_frame(8, 2, 0, 8, 0, 2, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 48'h000000_FFFFFF);
    pat = '{8'd90, 8'd81, 8'd240, 8'd81};
    run_frame(8, 2, 0, 8, 0, 2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 48'hFF0000_FF0000);
    pat = '{8'd128, 8'd16, 8'd128, 8'd16};
    run_frame(8, 2, 0, 8, 0, 2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 48'h000000_000000);
    pat.delete();

    // Three pairs against a full FIFO, then a clean frame to clear OVF.
    run_frame(6, 1, 0, 6, 0, 1, 1'b0, 1'b1, 100, 0, 1'b0, 1'b0, 1'b0, 48'd0);
    run_frame(8, 2, 0, 8, 0, 2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 48'd0);
    // CAPON raised mid-frame takes effect only at the next frame start.
    run_frame(8, 2, 0, 8, 0, 2, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 48'd0);
    run_frame(8, 2, 0, 8, 0, 2, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 48'd0);
    // Crop edge exactly at line end, window beyond active area, truncations.
    run_frame(16, 4, 4, 12, 1, 2, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 48'd0);
    run_frame(16, 4, 10, 20, 2, 9, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 48'd0);
    run_frame(12, 3, 0, 12, 0, 3, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 48'd0);
    run_frame(12, 3, 0, 12, 0, 3, 1'b1, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0, 48'd0);

    for (int f = 0; f < 40; f++) begin
      wpx = 2 * $urandom_range(2, 12);
      nl  = $urandom_range(2, 6);
      hs  = 2 * $urandom_range(0, wpx / 2);
      hsz = 2 * $urandom_range(1, wpx / 2 + 2);
      if ($urandom_range(3) == 0) begin
        hs  = 2 * $urandom_range(0, wpx / 2 - 1);
        hsz = wpx - hs;
      end
      vs  = $urandom_range(0, nl - 1);
      vsz = $urandom_range(1, nl + 1);
      tr  = ($urandom_range(7) == 0) ? $urandom_range(1, 2) : 0;
      run_frame(wpx, nl, hs, hsz, vs, vsz, 1'($urandom_range(1)), ($urandom_range(3) != 0),
                ($urandom_range(2) == 0) ? 30 : 0, tr, ($urandom_range(4) == 0),
                1'($urandom_range(1)), 1'b0, 48'd0);
    end

    // Enough armed frames for FRMCNT to wrap through zero.
    for (int f = 0; f < 258; f++)
      run_frame(2, 1, 0, 2, 0, 1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 48'd0);

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cap_decoder_win.md
# cap_decoder_win

Parametrised camera-byte-stream decoder for the capture path. It converts 8-bit YUV 4:2:2 camera data into pairs of 24-bit RGB pixels and writes them to the capture FIFO. It sits between the camera pins (PCLK domain) and the capture FIFO. Compared with the fixed-resolution decoder, it adds:

- a run-time crop window,
- selectable byte order,
- frame-aligned capture enable,
- a pipelined, rounded colour conversion,
- FIFO back-pressure handling with overflow flag and frame counter.

## Interface
Parameters:
- CNT_W, 12, width of byte/pixel/line counters and window inputs
- FCNT_W, 8, width of FRMCNT

Ports:
- PCLK  in  1  camera pixel clock; sole clock
- PRST  in  1  synchronous, active-high reset
- CAMDATA  in  8  camera data byte
- HREF  in  1  line-valid
- VSYNC  in  1  frame sync, high between frames
- CAPON  in  1  capture enable request
- ORDER  in  1  0 = U Y0 V Y1 byte order, 1 = Y0 U Y1 V
- HSTART  in  CNT_W  first captured pixel column (even)
- HSIZE  in  CNT_W  captured pixels per line (even, ≥2)
- VSTART  in  CNT_W  first captured line
- VSIZE  in  CNT_W  captured lines (≥1)
- FIFOFULL  in  1  capture FIFO full
- FIFOIN  out  48  {R1,G1,B1,R0,G0,B0}
- FIFOWR  out  1  write strobe, one word per pixel pair
- FIFORST  out  1  FIFO reset
- CAPACT  out  1  capture armed for the current frame
- OVF  out  1  sticky overflow (word dropped)
- FRMCNT  out  FCNT_W  frames completed while armed

## Operation
Input stage:
- CAMDATA, HREF and VSYNC are registered (cam_ff, href_ff, vsync_ff).
- All later logic uses the registered copies only.

Frame start is defined as the falling edge of vsync_ff. At frame start:
- CAPACT <= CAPON.
- OVF cleared.
- Line counter cleared.
- CAPON changes mid-frame have no effect until the next frame start.

Counters:
- Byte counter bcnt counts while href_ff=1 and clears to 0 while href_ff=0.
- Pixel column x = bcnt>>1. Pair phase = bcnt[1:0].
- Line counter lcnt increments on each href_ff 1→0 transition. It saturates at all-ones.
- bcnt and lcnt are held at 0 while vsync_ff=1.

Byte demux:
- ORDER=0: phase 0→U, 1→Y0, 2→V, 3→Y1.
- ORDER=1: phase 0→Y0, 1→U, 2→Y1, 3→V.
- On phase 3, the quad {U,Y0,V,Y1} is latched and q_valid pulses for 1 cycle.
- q_valid is qualified by all of the following:
  - CAPACT
  - HSTART ≤ x_pair < HSTART+HSIZE, where x_pair = column of Y0
  - VSTART ≤ lcnt < VSTART+VSIZE
- Window comparisons use CNT_W+1 bits, so the sums cannot wrap.

Conversion (per pixel n∈{0,1}, signed ≥20-bit arithmetic):
- C = 298·(Yn−16), D = U−128, E = V−128
- R = (C + 409·E + 128)>>>8
- G = (C − 100·D − 208·E + 128)>>>8
- B = (C + 516·D + 128)>>>8
- Each result is clamped: <0 → 0, >255 → 255.
- Y1 is used for pixel 1 (the old Y0 reuse defect is fixed).
- Pipeline: stage 1 registers the products; stage 2 registers the sums and clamped outputs.

FIFO handling:
- FIFOWR = stage-2 valid AND NOT FIFOFULL.
- If stage-2 valid and FIFOFULL=1:
  - the word is dropped (no stall, no retry);
  - OVF <= 1, held until the next frame start or PRST.
- FIFORST = PRST OR vsync_ff (combinational).

Frame counter:
- FRMCNT increments at frame start if CAPACT was 1 for the ending frame.
- It wraps from all-ones to 0.

## Timing
- Latency: 4th byte of a quad sampled on CAMDATA at edge k gives FIFOWR=1 and valid FIFOIN during the cycle after edge k+3.
- FIFOWR is high for exactly 1 cycle per pair, at most 1 per 4 cycles.
- FIFOIN holds its last value when FIFOWR=0.
- Reset (PRST=1 at an edge) sets:
  - all counters, pipeline valids, FIFOWR, CAPACT and OVF to 0;
  - FIFOIN and FRMCNT to 0;
  - FIFORST=1 while PRST=1.
- Reset mid-line discards any partial quad and in-flight pipeline data. Capture resumes only after the next frame start.
- vsync_ff=1 mid-line (truncated frame) clears the counters and pipeline valids on the same edge, so no FIFOWR is issued after it.
- HREF dropping mid-quad discards the partial quad.
- Window edge: HSTART+HSIZE equal to the line width is valid. A window beyond the active area simply writes fewer words.
- Simultaneous FIFOFULL deassertion and stage-2 valid: the write happens; FIFOFULL is sampled in the same cycle.

## Test plan
- VGA frame, window 0/640/0/480, ORDER=0, Y=16 U=V=128 → 320×480 = 153600 writes, all FIFOIN=0, OVF=0, FRMCNT=1.
- Quad Y0=235, Y1=16, U=V=128 → FIFOIN={FFFFFF,000000} pixel order R1G1B1R0G0B0 = 48'h000000_FFFFFF, FIFOWR 4 cycles after 4th byte.
- ORDER=1 with bytes 235,128,16,128 → same word as above. Y=81 U=90 V=240 → R0=255, G0=0, B0=0 after clamping.
- Crop HSTART=256 HSIZE=1024 VSTART=256 VSIZE=768 on a 1280×1024 frame → 512 writes per line on lines 256..1023 only, total 393216.
- CAPON raised mid-frame → no writes that frame, CAPACT=1 and writes from the next frame. FIFOFULL=1 for 3 pairs → 3 words dropped, OVF=1 until next frame start.
- PRST pulse mid-line, and VSYNC asserted mid-line → FIFOWR=0 immediately, FIFORST=1, no partial word written. 256 armed frames → FRMCNT wraps to 0.
